// File: rtl/klp32_pkg.sv
// rtl/klp32_pkg.sv - shared scoreboard slot type, width helper and defaults
package klp32_pkg;

    localparam int SB_NUM_REGS_DEF = 32;
    localparam int SB_DEPTH_DEF    = 3;
    // Widest register index a slot can carry; NUM_REGS up to 256.
    localparam int SB_RD_W         = 8;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               wr_en;
        logic               is_load;
    } sb_slot_t;

    // Width of a forward select: 0 = register file, k+1 = slot k.
    function automatic int fwd_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - one slot versus one source operand hazard compare
module sb_match
    import klp32_pkg::*;
(
    input  logic               slot_valid,
    input  logic               slot_wr_en,
    input  logic [SB_RD_W-1:0] slot_rd,
    input  logic [SB_RD_W-1:0] rs,
    input  logic               rs_used,
    output logic               hit
);

    assign hit = slot_valid & slot_wr_en & rs_used & (rs != '0) & (slot_rd == rs);

endmodule

// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - in-flight destination tracking with stall and bypass select
module pipeline_scoreboard
    import klp32_pkg::*;
#(
    parameter int NUM_REGS = SB_NUM_REGS_DEF,
    parameter int DEPTH    = SB_DEPTH_DEF,
    parameter int FWD_EN   = 1,
    parameter int RAW      = $clog2(NUM_REGS),
    parameter int FW       = fwd_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_issue_valid,
    input  logic [RAW-1:0]   i_issue_rd,
    input  logic [RAW-1:0]   i_rs1,
    input  logic [RAW-1:0]   i_rs2,
    input  logic             i_issue_wr_en,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    input  logic             i_issue_is_load,
    input  logic [DEPTH-1:0] i_flush_mask,
    output logic             o_stall,
    output logic [FW-1:0]    o_fwd_rs1,
    output logic [FW-1:0]    o_fwd_rs2,
    output logic [FW-1:0]    o_inflight,
    output logic [31:0]      o_stall_cycles
);

    sb_slot_t           slots [DEPTH];
    sb_slot_t           live  [DEPTH];
    sb_slot_t           issue_slot;
    logic [DEPTH-1:0]   hit1;
    logic [DEPTH-1:0]   hit2;
    logic [SB_RD_W-1:0] rs1_ext;
    logic [SB_RD_W-1:0] rs2_ext;
    logic               stall;

    assign rs1_ext = SB_RD_W'(i_rs1);
    assign rs2_ext = SB_RD_W'(i_rs2);

    // Flushed slots drop out of hazard detection in the same cycle they are killed.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            live[k]       = slots[k];
            live[k].valid = slots[k].valid & ~i_flush_mask[k];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        sb_match u_match_rs1 (
            .slot_valid (live[k].valid),
            .slot_wr_en (live[k].wr_en),
            .slot_rd    (live[k].rd),
            .rs         (rs1_ext),
            .rs_used    (i_rs1_used),
            .hit        (hit1[k])
        );
        sb_match u_match_rs2 (
            .slot_valid (live[k].valid),
            .slot_wr_en (live[k].wr_en),
            .slot_rd    (live[k].rd),
            .rs         (rs2_ext),
            .rs_used    (i_rs2_used),
            .hit        (hit2[k])
        );
    end

    always_comb begin
        stall = 1'b0;
        if (FWD_EN != 0) begin
            stall = i_issue_valid & (hit1[0] | hit2[0]) & live[0].is_load;
        end else begin
            stall = i_issue_valid & ((|hit1) | (|hit2));
        end
    end

    // Scan oldest to youngest so the youngest matching slot is written last.
    always_comb begin
        o_fwd_rs1 = '0;
        o_fwd_rs2 = '0;
        if ((FWD_EN != 0) && !stall) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hit1[k]) o_fwd_rs1 = FW'(k + 1);
                if (hit2[k]) o_fwd_rs2 = FW'(k + 1);
            end
        end
    end

    assign o_stall = stall;

    always_comb begin
        issue_slot         = '0;
        issue_slot.valid   = i_issue_valid & ~stall;
        issue_slot.rd      = SB_RD_W'(i_issue_rd);
        issue_slot.wr_en   = i_issue_wr_en;
        issue_slot.is_load = i_issue_is_load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
            o_stall_cycles <= '0;
        end else begin
            slots[0] <= issue_slot;
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= live[k-1];
            end
            if (stall && (o_stall_cycles != 32'hFFFF_FFFF)) begin
                o_stall_cycles <= o_stall_cycles + 32'd1;
            end
        end
    end

    always_comb begin
        o_inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_inflight = o_inflight + FW'(slots[k].valid);
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - bench for pipeline_scoreboard, interlock and bypass builds
module tb_pipeline_scoreboard;

    localparam int D  = 3;
    localparam int NR = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         issue_valid = 1'b0;
    logic [4:0]   issue_rd = '0;
    logic [4:0]   rs1 = '0;
    logic [4:0]   rs2 = '0;
    logic         issue_wr_en = 1'b0;
    logic         rs1_used = 1'b0;
    logic         rs2_used = 1'b0;
    logic         issue_is_load = 1'b0;
    logic [D-1:0] flush_mask = '0;

    // Index 0 = interlock-only build, index 1 = bypass build.
    logic         stall_o [2];
    logic [1:0]   fwd1_o  [2];
    logic [1:0]   fwd2_o  [2];
    logic [1:0]   infl_o  [2];
    logic [31:0]  sc_o    [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipeline_scoreboard #(.NUM_REGS(NR), .DEPTH(D), .FWD_EN(0)) u_ilk (
        .clk(clk), .reset(reset), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_rs1(rs1), .i_rs2(rs2), .i_issue_wr_en(issue_wr_en), .i_rs1_used(rs1_used),
        .i_rs2_used(rs2_used), .i_issue_is_load(issue_is_load), .i_flush_mask(flush_mask),
        .o_stall(stall_o[0]), .o_fwd_rs1(fwd1_o[0]), .o_fwd_rs2(fwd2_o[0]),
        .o_inflight(infl_o[0]), .o_stall_cycles(sc_o[0])
    );

    pipeline_scoreboard #(.NUM_REGS(NR), .DEPTH(D), .FWD_EN(1)) u_fwd (
        .clk(clk), .reset(reset), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_rs1(rs1), .i_rs2(rs2), .i_issue_wr_en(issue_wr_en), .i_rs1_used(rs1_used),
        .i_rs2_used(rs2_used), .i_issue_is_load(issue_is_load), .i_flush_mask(flush_mask),
        .o_stall(stall_o[1]), .o_fwd_rs1(fwd1_o[1]), .o_fwd_rs2(fwd2_o[1]),
        .o_inflight(infl_o[1]), .o_stall_cycles(sc_o[1])
    );

    // Model: per build, the instructions in flight indexed by age in cycles.
    typedef struct {
        bit alive;
        int rd;
        bit wr_en;
        bit is_load;
    } ent_t;

    ent_t        m    [2][D];
    int unsigned m_sc [2];
    bit          m_st [2];

    function automatic int youngest(input int inst, input int rs, input bit used);
        for (int a = 0; a < D; a++) begin
            if (m[inst][a].alive && !flush_mask[a] && m[inst][a].wr_en && used &&
                rs != 0 && m[inst][a].rd == rs)
                return a;
        end
        return -1;
    endfunction

    function automatic bit exp_stall(input int inst);
        int y1;
        int y2;
        y1 = youngest(inst, int'(rs1), rs1_used);
        y2 = youngest(inst, int'(rs2), rs2_used);
        if (!issue_valid) return 1'b0;
        if (inst == 1) return (y1 == 0 || y2 == 0) && m[inst][0].is_load;
        return (y1 >= 0 || y2 >= 0);
    endfunction

    function automatic int exp_fwd(input int inst, input int y);
        if (inst == 0 || exp_stall(inst) || y < 0) return 0;
        return y + 1;
    endfunction

    function automatic int exp_infl(input int inst);
        int n;
        n = 0;
        for (int a = 0; a < D; a++) n += m[inst][a].alive ? 1 : 0;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                for (int a = 0; a < D; a++) m[i][a] = '{alive: 1'b0, rd: 0, wr_en: 1'b0, is_load: 1'b0};
                m_sc[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = exp_stall(i);
                for (int a = D - 1; a > 0; a--) begin
                    m[i][a]       = m[i][a-1];
                    m[i][a].alive = m[i][a-1].alive && !flush_mask[a-1];
                end
                if (issue_valid && !m_st[i])
                    m[i][0] = '{alive: 1'b1, rd: int'(issue_rd), wr_en: issue_wr_en, is_load: issue_is_load};
                else
                    m[i][0] = '{alive: 1'b0, rd: 0, wr_en: 1'b0, is_load: 1'b0};
                if (m_st[i] && m_sc[i] != 32'hFFFF_FFFF) m_sc[i]++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model.stall[%0d]", i), 64'(stall_o[i]), 64'(exp_stall(i)));
            check($sformatf("model.fwd_rs1[%0d]", i), 64'(fwd1_o[i]),
                  64'(exp_fwd(i, youngest(i, int'(rs1), rs1_used))));
            check($sformatf("model.fwd_rs2[%0d]", i), 64'(fwd2_o[i]),
                  64'(exp_fwd(i, youngest(i, int'(rs2), rs2_used))));
            check($sformatf("model.inflight[%0d]", i), 64'(infl_o[i]), 64'(exp_infl(i)));
            check($sformatf("model.stall_cycles[%0d]", i), 64'(sc_o[i]), 64'(m_sc[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input bit v, input int rd, input bit we, input bit ld,
                           input int a, input bit ua, input int b, input bit ub);
        issue_valid   = v;
        issue_rd      = 5'(rd);
        issue_wr_en   = we;
        issue_is_load = ld;
        rs1           = 5'(a);
        rs1_used      = ua;
        rs2           = 5'(b);
        rs2_used      = ub;
    endtask

    task automatic idle_drain();
        present(0, 0, 0, 0, 0, 0, 0, 0);
        flush_mask = '0;
        repeat (5) tick();
    endtask

    task automatic do_reset();
        present(0, 0, 0, 0, 0, 0, 0, 0);
        flush_mask = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("reset.inflight", 64'(infl_o[1]), 64'd0);
        check("reset.stall_cycles", 64'(sc_o[1]), 64'd0);
        check("reset.stall", 64'(stall_o[1]), 64'd0);
        reset = 1'b0;

        // ALU writer x5 then reader: bypass from slot 0, interlock stalls.
        present(1, 5, 1, 0, 0, 0, 0, 0); tick();
        present(1, 10, 1, 0, 5, 1, 0, 0); settle();
        check("alu.fwd_stall", 64'(stall_o[1]), 64'd0);
        check("alu.fwd_rs1", 64'(fwd1_o[1]), 64'd1);
        check("alu.ilk_stall", 64'(stall_o[0]), 64'd1);
        tick();
        present(1, 5, 1, 0, 0, 0, 0, 0); tick();
        present(1, 17, 1, 0, 5, 1, 10, 1); settle();
        check("youngest.fwd_rs1", 64'(fwd1_o[1]), 64'd1);
        check("youngest.fwd_rs2", 64'(fwd2_o[1]), 64'd2);
        tick();
        idle_drain();

        // Load-use: one bubble, then bypass from slot 1.
        do_reset();
        present(1, 7, 1, 1, 0, 0, 0, 0); tick();
        present(1, 11, 1, 0, 0, 0, 7, 1); settle();
        check("load.stall", 64'(stall_o[1]), 64'd1);
        check("load.fwd_rs2_stalled", 64'(fwd2_o[1]), 64'd0);
        tick(); settle();
        check("load.stall_released", 64'(stall_o[1]), 64'd0);
        check("load.fwd_rs2", 64'(fwd2_o[1]), 64'd2);
        tick();
        present(0, 0, 0, 0, 0, 0, 0, 0); settle();
        check("load.stall_cycles", 64'(sc_o[1]), 64'd1);
        idle_drain();

        // Interlock holds the x3 reader until the writer retires.
        do_reset();
        present(1, 3, 1, 0, 0, 0, 0, 0); tick();
        present(1, 12, 1, 0, 3, 1, 0, 0);
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("ilk.stall_c%0d", c), 64'(stall_o[0]), (c < 3) ? 64'd1 : 64'd0);
            tick();
        end
        present(0, 0, 0, 0, 0, 0, 0, 0); settle();
        check("ilk.stall_cycles", 64'(sc_o[0]), 64'd3);
        check("ilk.fwd_build_stall_cycles", 64'(sc_o[1]), 64'd0);
        idle_drain();

        // Flushing the slot-1 writer removes its hazard at once.
        do_reset();
        present(1, 9, 1, 0, 0, 0, 0, 0); tick();
        present(0, 0, 0, 0, 0, 0, 0, 0); tick();
        flush_mask = 3'b010;
        present(1, 12, 1, 0, 9, 1, 0, 0); settle();
        check("flush.fwd_rs1_same", 64'(fwd1_o[1]), 64'd0);
        check("flush.fwd_stall_same", 64'(stall_o[1]), 64'd0);
        check("flush.ilk_stall_same", 64'(stall_o[0]), 64'd0);
        tick();
        flush_mask = '0; settle();
        check("flush.fwd_rs1_next", 64'(fwd1_o[1]), 64'd0);
        check("flush.ilk_stall_next", 64'(stall_o[0]), 64'd0);
        check("flush.inflight", 64'(infl_o[1]), 64'd1);
        tick();
        idle_drain();

        // Bit 0 of the mask kills the old slot 0 entry, not the issuing one.
        do_reset();
        present(1, 8, 1, 0, 0, 0, 0, 0); tick();
        flush_mask = 3'b001;
        present(1, 13, 1, 0, 0, 0, 0, 0); tick();
        flush_mask = '0;
        present(1, 14, 1, 0, 8, 1, 13, 1); settle();
        check("flush0.fwd_rs1", 64'(fwd1_o[1]), 64'd0);
        check("flush0.fwd_rs2", 64'(fwd2_o[1]), 64'd1);
        check("flush0.inflight", 64'(infl_o[1]), 64'd1);
        check("flush0.ilk_stall", 64'(stall_o[0]), 64'd1);
        tick();
        idle_drain();

        // x0 destinations, unused sources and non-writers never create hazards.
        do_reset();
        present(1, 0, 1, 0, 0, 0, 0, 0); tick();
        present(1, 4, 1, 0, 0, 1, 0, 1); settle();
        check("x0.fwd_stall", 64'(stall_o[1]), 64'd0);
        check("x0.ilk_stall", 64'(stall_o[0]), 64'd0);
        check("x0.fwd_rs1", 64'(fwd1_o[1]), 64'd0);
        tick();
        present(1, 6, 0, 0, 4, 0, 4, 0); settle();
        check("unused.ilk_stall", 64'(stall_o[0]), 64'd0);
        check("unused.fwd_rs1", 64'(fwd1_o[1]), 64'd0);
        tick();
        present(1, 15, 1, 0, 6, 1, 0, 0); settle();
        check("nowr.ilk_stall", 64'(stall_o[0]), 64'd0);
        check("nowr.fwd_rs1", 64'(fwd1_o[1]), 64'd0);
        check("nowr.inflight", 64'(infl_o[1]), 64'd3);
        tick();
        idle_drain();

        // Asynchronous reset between edges with a load-use stall pending.
        do_reset();
        present(1, 7, 1, 1, 0, 0, 0, 0); tick();
        present(1, 16, 1, 0, 7, 1, 0, 0); settle();
        check("async.stall_before", 64'(stall_o[1]), 64'd1);
        check("async.inflight_before", 64'(infl_o[1]), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async.inflight", 64'(infl_o[1]), 64'd0);
        check("async.stall", 64'(stall_o[1]), 64'd0);
        check("async.ilk_inflight", 64'(infl_o[0]), 64'd0);
        check("async.fwd_rs1", 64'(fwd1_o[1]), 64'd0);
        tick();
        reset = 1'b0; settle();
        check("async.no_stale_stall", 64'(stall_o[1]), 64'd0);
        check("async.no_stale_fwd", 64'(fwd1_o[1]), 64'd0);
        tick();
        idle_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 Parameter DEPTH, default 3, number of tracked in-flight slots from execute to writeback; legal range 1..8.
REQ-003 Parameter FWD_EN, default 1, 1 = bypass network present, 0 = interlock-only.
REQ-004 Parameter RAW = $clog2(NUM_REGS); FW = $clog2(DEPTH+1).
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 i_issue_valid  in  1  decode presents an instruction this cycle.
REQ-008 i_issue_rd, i_rs1, i_rs2  in  RAW each  destination and source register indices.
REQ-009 i_issue_wr_en, i_rs1_used, i_rs2_used, i_issue_is_load  in  1 each  qualifiers for the presented instruction.
REQ-010 i_flush_mask  in  DEPTH  bit k kills slot k this cycle.
REQ-011 o_stall  out  1  hold fetch/decode, insert bubble into slot 0.
REQ-012 o_fwd_rs1, o_fwd_rs2  out  FW each  0 = register file, k+1 = forward from slot k.
REQ-013 o_inflight  out  FW  count of valid slots.
REQ-014 o_stall_cycles  out  32  saturating count of cycles with o_stall=1.

Function
REQ-015 Slot k (0 = execute, DEPTH-1 = writeback) SHALL hold {valid, rd, wr_en, is_load}.
REQ-016 A slot SHALL be a hazard source for rsN only if valid, wr_en, rd==rsN, rsN!=0 and rsN_used.
REQ-017 With FWD_EN=1, o_stall SHALL assert iff i_issue_valid and a hazard source in slot 0 has is_load=1.
REQ-018 With FWD_EN=0, o_stall SHALL assert iff i_issue_valid and any slot is a hazard source.
REQ-019 o_fwd_rsN SHALL select the lowest-index (youngest) matching hazard source; 0 when none, when FWD_EN=0, or when o_stall=1.
REQ-020 o_stall and o_fwd_* SHALL be combinational from slot state and current inputs; zero added latency.
REQ-021 Each cycle slots SHALL shift k -> k+1; slot DEPTH-1 retires and is discarded.
REQ-022 Slot 0 SHALL load the presented instruction when i_issue_valid=1 and o_stall=0, else a bubble (valid=0).
REQ-023 Flush SHALL clear valid of masked slots before the shift; flushed entries never forward or stall.
REQ-024 Simultaneous flush and issue: the issued instruction enters slot 0 unless bit 0 of a same-cycle mask targets it; the mask applies to pre-shift slots only.
REQ-025 o_inflight SHALL reflect registered slot state (post-update, one cycle after issue).
REQ-026 o_stall_cycles SHALL increment by 1 per stall cycle and hold at 32'hFFFF_FFFF.
REQ-027 rd=0 or wr_en=0 instructions SHALL occupy a slot but never create hazards.

Reset
REQ-028 On reset assertion, all slot valid bits, o_inflight and o_stall_cycles SHALL clear immediately, independent of clk.
REQ-029 During reset o_stall=0 and o_fwd_rs1=o_fwd_rs2=0.
REQ-030 Reset mid-operation SHALL discard all in-flight entries; no stale forwarding after release.

Structure
REQ-031 Shared package klp32_pkg SHALL hold the sb_slot_t struct, the fwd_sel_t width helper and DEPTH/NUM_REGS defaults.
REQ-032 One sub-module, sb_match, SHALL implement per-slot comparison (slot, rs, rs_used -> hit), instantiated 2*DEPTH times.
REQ-033 Priority encode for forwarding SHALL live in pipeline_scoreboard.

Verification
REQ-034 FWD_EN=1: issue add x5; next cycle issue rs1=x5 -> o_stall=0, o_fwd_rs1=1.
REQ-035 FWD_EN=1: issue load x7; next cycle rs2=x7 -> o_stall=1 for one cycle, then o_fwd_rs2=2; o_stall_cycles=1.
REQ-036 FWD_EN=0, DEPTH=3: issue x3 writer, then x3 reader -> o_stall held 3 cycles, released when x3 entry retires.
REQ-037 Writer x9 in slot 1, flush_mask=3'b010, same-cycle reader rs1=x9 -> o_fwd_rs1=0 next cycle, no stall.
REQ-038 Writers rd=x0 and rs1_used=0 reader -> o_stall=0, o_fwd_rs1=0 throughout.
REQ-039 Load in slot 0, reset asserted between clock edges -> o_inflight=0 and o_stall=0 immediately.
